load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the processor memory stage and data_memory (word-wide, synchronous read, word write only, indexed by address[13:2]).
- Accepts byte, halfword and word load/store requests through a valid/ready handshake.
- Performs alignment checks, range checks, sign/zero extension on loads, and read-modify-write for sub-word stores.
- Returns one response per request.

Parameters:
MEM_BYTES, 16384, size of the data_memory address space in bytes; any address >= MEM_BYTES is an error.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data; the sub-word value is in the low bits
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  qualifies resp_valid; set for misaligned, illegal-size or out-of-range requests
resp_rdata  output  32  extended load data; 0 for stores and errors
mem_write  output  1  to data_memory mem_write
mem_address  output  32  to data_memory address; word aligned ({addr[31:2],2'b00})
mem_write_data  output  32  to data_memory write_data
mem_read_data  input  32  from data_memory read_data; valid the cycle after the address is presented

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_address=0, mem_write_data=0. State returns to IDLE.
- mem_write is forced to 0 whenever rst=1, in the same cycle.
- States: IDLE, WRITE, READ, CAPTURE, MERGE, RESP.
- req_ready=1 only in IDLE. A request is accepted on the edge where req_valid & req_ready; its fields are latched then and held for the whole operation.
- Error check at accept. Error conditions:
  - size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr > MEM_BYTES - (bytes of size).
  - On error: go directly to RESP with resp_err=1. No memory access is made.
- Word store: IDLE -> WRITE (mem_write=1, data=wdata) -> RESP. resp_valid is asserted 2 cycles after accept.
- Load: IDLE -> READ (address driven) -> CAPTURE -> RESP. resp_valid is asserted 3 cycles after accept.
  - CAPTURE selects the lane from mem_read_data, extends it, and registers it into resp_rdata.
- Sub-word store: IDLE -> READ -> MERGE -> RESP. resp_valid is asserted 3 cycles after accept.
  - In MERGE, mem_write=1 for exactly one cycle.
  - mem_write_data = mem_read_data with only the target lane(s) replaced by wdata[7:0] or wdata[15:0].
- Lane selection is little-endian:
  - byte lane = addr[1:0];
  - halfword: addr[1]=0 gives bits 15:0, addr[1]=1 gives bits 31:16.
- mem_address is held constant from READ/WRITE through MERGE. mem_write=0 in every state other than WRITE and MERGE.
- RESP lasts one cycle, then returns to IDLE. A request offered during RESP is not accepted until the next cycle (IDLE). Back-to-back accept period: 3 cycles (word store) or 4 cycles (load, sub-word store).
- resp_rdata and resp_err are held until the next RESP; they are only meaningful while resp_valid=1.
- Reset mid-operation, any state: the next state is IDLE, no response is produced, and mem_write is 0 during the reset cycle.
  - A sub-word store interrupted before MERGE leaves memory unmodified.
- req_valid may be dropped while not ready without effect. No request is buffered.

Test Plan:
- Word store 0xAABBCCDD @0x0004, then word load @0x0004:
  - mem_write high exactly one cycle, mem_address=0x4;
  - load resp_valid 3 cycles after accept, resp_rdata=0xAABBCCDD, resp_err=0.
- Preload 0xFEEDFACE @0x1000, byte store wdata=0x00000011 @0x1001:
  - MERGE writes 0xFEED11CE;
  - word load returns 0xFEED11CE.
- Loads from 0x1000=0xFEED11CE:
  - signed byte @0x1003 -> 0xFFFFFFFE;
  - unsigned byte @0x1003 -> 0x000000FE;
  - signed half @0x1002 -> 0xFFFFFEED;
  - unsigned half @0x1000 -> 0x000011CE.
- Errors, each giving resp_err=1 one cycle after accept, resp_rdata=0 and mem_write never asserted:
  - halfword store @0x1001;
  - word load @0x1002;
  - size=11;
  - word load @0x4000 (MEM_BYTES=16384);
  - byte load @0x3FFF succeeds.
- Reset mid-RMW: byte store @0x1000 accepted, rst=1 during READ:
  - no resp_valid, mem_write stays 0;
  - word @0x1000 unchanged;
  - req_ready=1 the cycle after rst deasserts.
- Handshake: req_valid held high with 3 queued requests (word store, load, byte store):
  - exactly one accept per IDLE visit, responses in order;
  - req_ready=0 in all non-IDLE cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a word-wide data memory with
// synchronous read and word-only write.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   req_valid / req_ready        request handshake; accepted when both are high
//   req_write, req_size,         request fields: store/load, size (00 byte,
//   req_unsigned, req_addr,      01 half, 10 word), zero-extend for loads,
//   req_wdata                    byte address, store data in the low bits
//   resp_valid, resp_err,        one-cycle response pulse, error flag and
//   resp_rdata                   extended load data (0 for stores/errors)
//   mem_write, mem_address,      data memory write strobe, word-aligned address,
//   mem_write_data               and write data
//   mem_read_data                data memory read data (one cycle after address)
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    StIdle, StWrite, StRead, StCapture, StMerge, StResp
  } state_e;

  // Highest legal start address for each access size.
  localparam logic [31:0] LimitByte = 32'(MEM_BYTES - 1);
  localparam logic [31:0] LimitHalf = 32'(MEM_BYTES - 2);
  localparam logic [31:0] LimitWord = 32'(MEM_BYTES - 4);

  state_e      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_address_q;
  logic        mem_write_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Alignment, size and range checks on the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = (req_addr > LimitByte);
      2'b01:   req_err = req_addr[0] | (req_addr > LimitHalf);
      2'b10:   req_err = (req_addr[1:0] != 2'b00) | (req_addr > LimitWord);
      default: req_err = 1'b1;
    endcase
  end

  // Little-endian lane extraction and sign/zero extension for loads.
  always_comb begin
    rd_byte  = mem_read_data[{lane_q, 3'b000} +: 8];
    rd_half  = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_ext = mem_read_data;
    case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{~unsigned_q & rd_half[15]}}, rd_half};
      default: load_ext = mem_read_data;
    endcase
  end

  // Read-modify-write: replace only the addressed lane(s) of the old word.
  always_comb begin
    merged = mem_read_data;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 32'h0;
      mem_address_q <= 32'h0;
      mem_write_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'h0;
    end else begin
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata;
            if (req_err) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              mem_address_q <= {req_addr[31:2], 2'b00};
              if (req_write && (req_size == 2'b10)) begin
                state_q     <= StWrite;
                mem_write_q <= 1'b1;
              end else begin
                state_q <= StRead;
              end
            end
          end
        end
        StWrite: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        StRead: begin
          // Read data for the latched address is available in the next state.
          if (write_q) begin
            state_q     <= StMerge;
            mem_write_q <= 1'b1;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_ext;
        end
        StMerge: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  // Reset suppresses a pending write in the same cycle.
  assign mem_write      = mem_write_q & ~rst;
  assign mem_address    = mem_address_q;
  // Merged data depends on the read word, which only arrives in MERGE.
  assign mem_write_data = (state_q == StMerge) ? merged : wdata_q;

endmodule
